mano_mem_arbiter: RTL and testbench

//  - Arbitrates the single-ported Mano main memory between two requesters: port 0 (instruction-fetch cache) and port 1 (data cache).
//  - Sits between the dmc256x16 cache instances and the memory model; sequences one fixed-latency read or write at a time.
//  - Uses round-robin priority and raises a one-cycle completion pulse per transaction.

---
 rtl/mano_mem_arbiter_pkg.sv | 28 ++
 rtl/rr_arb2.sv | 23 ++
 rtl/mano_mem_arbiter.sv | 215 +++++++++++++++++++++
 tb/tb_mano_mem_arbiter.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mano_mem_arbiter_pkg.sv
// Shared widths, FSM encodings and helpers for the Mano memory arbiter.
// The address and data widths match the Mano main memory (4K x 16).

package mano_mem_arbiter_pkg;

    // Word address and data widths of the Mano main memory
    localparam int unsigned ADDR_W = 12;
    localparam int unsigned DATA_W = 16;

    // Latency counter width; MEM_LAT is legal from 1 to 15
    localparam int unsigned CNT_W = 4;

    // Statistics counter width
    localparam int unsigned STAT_W = 16;

    // FSM state encodings
    localparam logic ARB_IDLE = 1'b0;
    localparam logic ARB_BUSY = 1'b1;

    // Saturating increment for the statistics counters
    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        if (v == {STAT_W{1'b1}}) begin
            return v;
        end
        return v + STAT_W'(1);
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick. Combinational only: the owner of the "last"
// state is the caller, which updates it when a grant is actually taken.

module rr_arb2 (
    input  logic req0,
    input  logic req1,
    input  logic last,   // port that won the most recent grant
    output logic sel,    // 0 = port 0, 1 = port 1
    output logic valid   // at least one request present
);

    // Single requester wins outright; on conflict the port that did not win last time goes
    always_comb begin
        valid = req0 | req1;
        sel   = 1'b0;
        if (req0 && req1) begin
            sel = ~last;
        end else if (req1) begin
            sel = 1'b1;
        end
    end

endmodule

// File: rtl/mano_mem_arbiter.sv
// Mano main-memory arbiter: shares one single-ported memory between the
// instruction-fetch cache (port 0) and the data cache (port 1). One fixed
// latency access at a time, round-robin on conflict, one-cycle done pulse.
// Optional feature: define ARB_STATS_EN to add saturating grant/conflict
// counters (stat_gnt0, stat_gnt1, stat_conf).

module mano_mem_arbiter
    import mano_mem_arbiter_pkg::*;
#(
    parameter int unsigned MEM_LAT = 2   // strobe cycles per access, 1..15
) (
    input  logic              clk,
    input  logic              clr_n,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              done0,
    output logic              done1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              busy,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [DATA_W-1:0] mem_dout,
    input  logic [DATA_W-1:0] mem_din
`ifdef ARB_STATS_EN
    ,
    output logic [STAT_W-1:0] stat_gnt0,
    output logic [STAT_W-1:0] stat_gnt1,
    output logic [STAT_W-1:0] stat_conf
`endif
);

    localparam logic [CNT_W-1:0] CntLoad = CNT_W'(MEM_LAT - 1);

    logic              state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              last_q, last_d;
    logic              gnt0_q, gnt0_d;
    logic              gnt1_q, gnt1_d;
    logic              done0_q, done0_d;
    logic              done1_q, done1_d;
    logic [DATA_W-1:0] rdata0_q, rdata0_d;
    logic [DATA_W-1:0] rdata1_q, rdata1_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_dout_q, mem_dout_d;
    logic              mem_rd_q, mem_rd_d;
    logic              mem_wr_q, mem_wr_d;

    logic              arb_sel;
    logic              arb_valid;
    logic              sel_we;
    logic              grant;

    rr_arb2 u_rr_arb2 (
        .req0  (req0),
        .req1  (req1),
        .last  (last_q),
        .sel   (arb_sel),
        .valid (arb_valid)
    );

    // Requests are only looked at in IDLE; BUSY ignores them entirely
    assign grant  = (state_q == ARB_IDLE) && arb_valid;
    assign sel_we = arb_sel ? we1 : we0;

    // Next-state: grant in IDLE, count down latency in BUSY, complete at zero
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        last_d     = last_q;
        gnt0_d     = gnt0_q;
        gnt1_d     = gnt1_q;
        done0_d    = 1'b0;
        done1_d    = 1'b0;
        rdata0_d   = rdata0_q;
        rdata1_d   = rdata1_q;
        mem_addr_d = mem_addr_q;
        mem_dout_d = mem_dout_q;
        mem_rd_d   = mem_rd_q;
        mem_wr_d   = mem_wr_q;

        case (state_q)
            ARB_IDLE: begin
                if (grant) begin
                    state_d    = ARB_BUSY;
                    gnt0_d     = ~arb_sel;
                    gnt1_d     = arb_sel;
                    mem_addr_d = arb_sel ? addr1 : addr0;
                    mem_dout_d = arb_sel ? wdata1 : wdata0;
                    mem_rd_d   = ~sel_we;
                    mem_wr_d   = sel_we;
                    cnt_d      = CntLoad;
                    last_d     = arb_sel;
                end
            end
            ARB_BUSY: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    // Read data is captured only into the owning port's register
                    if (mem_rd_q && gnt0_q) begin
                        rdata0_d = mem_din;
                    end
                    if (mem_rd_q && gnt1_q) begin
                        rdata1_d = mem_din;
                    end
                    done0_d  = gnt0_q;
                    done1_d  = gnt1_q;
                    gnt0_d   = 1'b0;
                    gnt1_d   = 1'b0;
                    mem_rd_d = 1'b0;
                    mem_wr_d = 1'b0;
                    state_d  = ARB_IDLE;
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset drops any in-flight access
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q    <= ARB_IDLE;
            cnt_q      <= '0;
            last_q     <= 1'b1;
            gnt0_q     <= 1'b0;
            gnt1_q     <= 1'b0;
            done0_q    <= 1'b0;
            done1_q    <= 1'b0;
            rdata0_q   <= '0;
            rdata1_q   <= '0;
            mem_addr_q <= '0;
            mem_dout_q <= '0;
            mem_rd_q   <= 1'b0;
            mem_wr_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            last_q     <= last_d;
            gnt0_q     <= gnt0_d;
            gnt1_q     <= gnt1_d;
            done0_q    <= done0_d;
            done1_q    <= done1_d;
            rdata0_q   <= rdata0_d;
            rdata1_q   <= rdata1_d;
            mem_addr_q <= mem_addr_d;
            mem_dout_q <= mem_dout_d;
            mem_rd_q   <= mem_rd_d;
            mem_wr_q   <= mem_wr_d;
        end
    end

    assign gnt0     = gnt0_q;
    assign gnt1     = gnt1_q;
    assign done0    = done0_q;
    assign done1    = done1_q;
    assign rdata0   = rdata0_q;
    assign rdata1   = rdata1_q;
    assign busy     = (state_q == ARB_BUSY);
    assign mem_addr = mem_addr_q;
    assign mem_rd   = mem_rd_q;
    assign mem_wr   = mem_wr_q;
    assign mem_dout = mem_dout_q;

`ifdef ARB_STATS_EN
    logic [STAT_W-1:0] stat_gnt0_q, stat_gnt0_d;
    logic [STAT_W-1:0] stat_gnt1_q, stat_gnt1_d;
    logic [STAT_W-1:0] stat_conf_q, stat_conf_d;

    // Count grants per port and IDLE cycles where both ports competed
    always_comb begin
        stat_gnt0_d = stat_gnt0_q;
        stat_gnt1_d = stat_gnt1_q;
        stat_conf_d = stat_conf_q;
        if (grant && !arb_sel) begin
            stat_gnt0_d = sat_inc(stat_gnt0_q);
        end
        if (grant && arb_sel) begin
            stat_gnt1_d = sat_inc(stat_gnt1_q);
        end
        if (grant && req0 && req1) begin
            stat_conf_d = sat_inc(stat_conf_q);
        end
    end

    // Statistics registers
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            stat_gnt0_q <= '0;
            stat_gnt1_q <= '0;
            stat_conf_q <= '0;
        end else begin
            stat_gnt0_q <= stat_gnt0_d;
            stat_gnt1_q <= stat_gnt1_d;
            stat_conf_q <= stat_conf_d;
        end
    end

    assign stat_gnt0 = stat_gnt0_q;
    assign stat_gnt1 = stat_gnt1_q;
    assign stat_conf = stat_conf_q;
`endif

endmodule

// File: tb/tb_mano_mem_arbiter.sv
// Directed bench for mano_mem_arbiter. Three instances share one stimulus:
// A (MEM_LAT=2) for read/write/conflict, B (MEM_LAT=4) for reset mid-access,
// C (MEM_LAT=1) for the back-to-back boundary case.

module tb_mano_mem_arbiter;
    import mano_mem_arbiter_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              clr_n;
    logic              req0, req1, we0, we1;
    logic [ADDR_W-1:0] addr0, addr1;
    logic [DATA_W-1:0] wdata0, wdata1;

    logic              gnt0_a, gnt1_a, done0_a, done1_a, busy_a, mem_rd_a, mem_wr_a;
    logic [DATA_W-1:0] rdata0_a, rdata1_a, mem_dout_a, mem_din_a;
    logic [ADDR_W-1:0] mem_addr_a;
    logic              gnt0_b, gnt1_b, done0_b, done1_b, busy_b, mem_rd_b, mem_wr_b;
    logic [DATA_W-1:0] rdata0_b, rdata1_b, mem_dout_b, mem_din_b;
    logic [ADDR_W-1:0] mem_addr_b;
    logic              gnt0_c, gnt1_c, done0_c, done1_c, busy_c, mem_rd_c, mem_wr_c;
    logic [DATA_W-1:0] rdata0_c, rdata1_c, mem_dout_c, mem_din_c;
    logic [ADDR_W-1:0] mem_addr_c;
`ifdef ARB_STATS_EN
    logic [STAT_W-1:0] stat_gnt0_a, stat_gnt1_a, stat_conf_a;
    logic [STAT_W-1:0] stat_gnt0_b, stat_gnt1_b, stat_conf_b;
    logic [STAT_W-1:0] stat_gnt0_c, stat_gnt1_c, stat_conf_c;
`endif

    int total = 0;
    int bad   = 0;

    // Memory model: fixed preload pattern, overridden by writes from instance A
    logic [DATA_W-1:0] wmem    [0:(1<<ADDR_W)-1];
    bit                written [0:(1<<ADDR_W)-1];

    function automatic logic [DATA_W-1:0] mem_init(input logic [ADDR_W-1:0] a);
        case (a)
            12'h0A5: return 16'h1234;
            12'h010: return 16'hAAAA;
            12'h020: return 16'h5555;
            default: return {4'h0, a} ^ 16'hC3C3;
        endcase
    endfunction

    function automatic logic [DATA_W-1:0] mem_rd_model(input logic [ADDR_W-1:0] a);
        return written[a] ? wmem[a] : mem_init(a);
    endfunction

    assign mem_din_a = mem_rd_model(mem_addr_a);
    assign mem_din_b = mem_rd_model(mem_addr_b);
    assign mem_din_c = mem_rd_model(mem_addr_c);

    always @(posedge clk) begin
        if (mem_wr_a) begin
            wmem[mem_addr_a]    <= mem_dout_a;
            written[mem_addr_a] <= 1'b1;
        end
    end

    mano_mem_arbiter #(.MEM_LAT(2)) u_dut_a (
        .clk(clk), .clr_n(clr_n), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0_a), .gnt1(gnt1_a), .done0(done0_a), .done1(done1_a),
        .rdata0(rdata0_a), .rdata1(rdata1_a), .busy(busy_a), .mem_addr(mem_addr_a),
        .mem_rd(mem_rd_a), .mem_wr(mem_wr_a), .mem_dout(mem_dout_a), .mem_din(mem_din_a)
`ifdef ARB_STATS_EN
        , .stat_gnt0(stat_gnt0_a), .stat_gnt1(stat_gnt1_a), .stat_conf(stat_conf_a)
`endif
    );

    mano_mem_arbiter #(.MEM_LAT(4)) u_dut_b (
        .clk(clk), .clr_n(clr_n), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0_b), .gnt1(gnt1_b), .done0(done0_b), .done1(done1_b),
        .rdata0(rdata0_b), .rdata1(rdata1_b), .busy(busy_b), .mem_addr(mem_addr_b),
        .mem_rd(mem_rd_b), .mem_wr(mem_wr_b), .mem_dout(mem_dout_b), .mem_din(mem_din_b)
`ifdef ARB_STATS_EN
        , .stat_gnt0(stat_gnt0_b), .stat_gnt1(stat_gnt1_b), .stat_conf(stat_conf_b)
`endif
    );

    mano_mem_arbiter #(.MEM_LAT(1)) u_dut_c (
        .clk(clk), .clr_n(clr_n), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0_c), .gnt1(gnt1_c), .done0(done0_c), .done1(done1_c),
        .rdata0(rdata0_c), .rdata1(rdata1_c), .busy(busy_c), .mem_addr(mem_addr_c),
        .mem_rd(mem_rd_c), .mem_wr(mem_wr_c), .mem_dout(mem_dout_c), .mem_din(mem_din_c)
`ifdef ARB_STATS_EN
        , .stat_gnt0(stat_gnt0_c), .stat_gnt1(stat_gnt1_c), .stat_conf(stat_conf_c)
`endif
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; sampling and driving happen 1ns after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        clr_n = 1'b0;
        tick();
        clr_n = 1'b1;
        tick();
    endtask

    // Wait on instance A for the done pulse of a port, counting strobe cycles
    task automatic wait_done_a(input int port, output int cyc, output int rd, output int wr);
        cyc = 0;
        rd  = 0;
        wr  = 0;
        while (((port == 0) ? done0_a : done1_a) == 1'b0 && cyc < 20) begin
            rd += int'(mem_rd_a);
            wr += int'(mem_wr_a);
            tick();
            cyc++;
        end
    endtask

    int cyc, rd, wr, n, viol;
    int order [4];

    initial begin
        clr_n = 1'b0;
        {req0, req1, we0, we1} = '0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        tick();
        tick();

        // Reset state
        check_eq("rst_gnt", {gnt0_a, gnt1_a, done0_a, done1_a}, 4'b0000);
        check_eq("rst_busy_strobes", {busy_a, mem_rd_a, mem_wr_a}, 3'b000);
        check_eq("rst_addr", mem_addr_a, 12'h000);
        clr_n = 1'b1;
        tick();

        // Single read, port 0
        req0 = 1'b1; we0 = 1'b0; addr0 = 12'h0A5;
        tick();
        check_eq("rd_grant", {gnt0_a, gnt1_a, busy_a, mem_rd_a, mem_wr_a}, 5'b10110);
        check_eq("rd_addr", mem_addr_a, 12'h0A5);
        wait_done_a(0, cyc, rd, wr);
        check_eq("rd_latency", cyc, 2);
        check_eq("rd_strobe_cycles", rd, 2);
        check_eq("rd_data", rdata0_a, 16'h1234);
        check_eq("rd_release", {gnt0_a, busy_a, mem_rd_a}, 3'b000);
        req0 = 1'b0;
        tick();
        check_eq("rd_done_pulse", done0_a, 1'b0);
        check_eq("rd_data_held", rdata0_a, 16'h1234);
        check_eq("idle_addr_held", mem_addr_a, 12'h0A5);

        // Single write, port 1
        req1 = 1'b1; we1 = 1'b1; addr1 = 12'h3F0; wdata1 = 16'hBEEF;
        tick();
        check_eq("wr_grant", {gnt0_a, gnt1_a, mem_rd_a, mem_wr_a}, 4'b0101);
        check_eq("wr_addr", mem_addr_a, 12'h3F0);
        check_eq("wr_dout", mem_dout_a, 16'hBEEF);
        wait_done_a(1, cyc, rd, wr);
        check_eq("wr_latency", cyc, 2);
        check_eq("wr_strobe_cycles", wr, 2);
        check_eq("wr_no_rd", rd, 0);
        check_eq("wr_mem", mem_rd_model(12'h3F0), 16'hBEEF);
        req1 = 1'b0; we1 = 1'b0;
        tick();
        check_eq("wr_done_pulse", done1_a, 1'b0);

        // Conflict after reset, both held: 0,1,0,1
        do_reset();
        req0 = 1'b1; addr0 = 12'h010;
        req1 = 1'b1; addr1 = 12'h020;
        n = 0; viol = 0; cyc = 0;
        while (n < 4 && cyc < 60) begin
            if ((gnt0_a && gnt1_a) || (mem_rd_a && mem_wr_a)) viol++;
            if (done0_a) begin order[n] = 0; n++; end
            if (done1_a && n < 4) begin order[n] = 1; n++; end
            tick();
            cyc++;
        end
        check_eq("conf_count", n, 4);
        check_eq("conf_order", {order[0][0], order[1][0], order[2][0], order[3][0]}, 4'b0101);
        check_eq("conf_exclusive", viol, 0);
        check_eq("conf_rdata0", rdata0_a, 16'hAAAA);
        check_eq("conf_rdata1", rdata1_a, 16'h5555);
        req0 = 1'b0; req1 = 1'b0;
        tick(); tick(); tick(); tick(); tick();

        // Reset in the 2nd BUSY cycle, MEM_LAT=4
        do_reset();
        req0 = 1'b1; we0 = 1'b0; addr0 = 12'h0A5;
        tick();
        check_eq("rstmid_grant", {gnt0_b, busy_b, mem_rd_b}, 3'b111);
        tick();
        clr_n = 1'b0;
        #1;
        check_eq("rstmid_outs", {gnt0_b, gnt1_b, busy_b, mem_rd_b, mem_wr_b, done0_b}, 6'b0);
        check_eq("rstmid_addr", mem_addr_b, 12'h000);
        tick();
        tick();
        check_eq("rstmid_no_done", {done0_b, done1_b, rdata0_b[0]}, 3'b000);
        clr_n = 1'b1;
        tick();
        check_eq("rstmid_regrant", {gnt0_b, done0_b, mem_rd_b}, 3'b101);
        cyc = 0;
        while (!done0_b && cyc < 20) begin
            tick();
            cyc++;
        end
        check_eq("rstmid_latency", cyc, 4);
        check_eq("rstmid_rdata", rdata0_b, 16'h1234);
        req0 = 1'b0;
        tick(); tick();

        // MEM_LAT=1, port 0 held: grant/done alternate every cycle
        do_reset();
        req0 = 1'b1; we0 = 1'b0; addr0 = 12'h0A5;
        tick();
        viol = 0;
        for (int i = 0; i < 6; i++) begin
            if (gnt0_c !== ((i % 2) == 0)) viol++;
            if (done0_c !== ((i % 2) == 1)) viol++;
            if ((mem_rd_c && mem_wr_c) || gnt1_c || done1_c) viol++;
            tick();
        end
        check_eq("lat1_pattern", viol, 0);
        check_eq("lat1_rdata", rdata0_c, 16'h1234);
        req0 = 1'b0;
        tick(); tick();

`ifdef ARB_STATS_EN
        // Three conflicts (port 0 wins each, port 1 follows) plus two solo port-0 reads
        do_reset();
        for (int k = 0; k < 3; k++) begin
            req0 = 1'b1; req1 = 1'b1;
            cyc = 0;
            while (!done0_a && cyc < 20) begin tick(); cyc++; end
            req0 = 1'b0;
            cyc = 0;
            while (!done1_a && cyc < 20) begin tick(); cyc++; end
            req1 = 1'b0;
            tick();
        end
        for (int k = 0; k < 2; k++) begin
            req0 = 1'b1;
            tick();
            cyc = 0;
            while (!done0_a && cyc < 20) begin tick(); cyc++; end
            req0 = 1'b0;
            tick();
        end
        check_eq("stat_gnt0", stat_gnt0_a, 16'd5);
        check_eq("stat_gnt1", stat_gnt1_a, 16'd3);
        check_eq("stat_conf", stat_conf_a, 16'd3);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
